free_list: RTL and testbench

- Circular FIFO of free physical register tags for the rename stage. It sits directly upstream of the RAT and supplies the rd_phys tag on every rename with a destination.
- Commit returns the superseded (old) physical tag to the list.
- A committed-head pointer allows single-cycle recovery of all speculative allocations on a pipeline flush.

---
 rtl/rename_pkg.sv | 14 +
 rtl/free_list.sv | 69 ++++++
 tb/tb_free_list.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Rename-stage shared constants and tag types, reused by the RAT, ROB, issue logic and free list.
package rename_pkg;

   localparam int unsigned ARCH_REGS   = 32;
   localparam int unsigned PHYS_REGS   = 64;
   localparam int unsigned PR_BITS     = $clog2(PHYS_REGS);
   localparam int unsigned FL_DEPTH    = PHYS_REGS - ARCH_REGS;
   localparam int unsigned FL_IDX_BITS = $clog2(FL_DEPTH);
   localparam int unsigned FL_PTR_BITS = FL_IDX_BITS + 1;

   typedef logic [PR_BITS-1:0]     phys_tag_t;
   typedef logic [FL_PTR_BITS-1:0] fl_ptr_t;

endpackage

// File: rtl/free_list.sv
// Circular list of free physical tags feeding rename; commit returns old tags and a
// committed-head pointer restores all speculative allocations in one cycle on flush.
module free_list
   import rename_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               alloc_req,
   output logic               alloc_valid,
   output logic [PR_BITS-1:0] alloc_phys,
   input  logic               commit_en,
   input  logic [PR_BITS-1:0] commit_old_phys,
   input  logic               flush,
   output logic [PR_BITS:0]   free_count
);

   phys_tag_t entries [FL_DEPTH];
   fl_ptr_t   head;
   fl_ptr_t   tail;
   fl_ptr_t   commit_head;
   fl_ptr_t   commit_head_nxt;
   fl_ptr_t   ptr_diff;
   logic      full;
   logic      do_alloc;
   logic      do_push;

   // Pointer difference carries the wrap bit, so 0 is empty and FL_DEPTH is full.
   assign ptr_diff    = fl_ptr_t'(tail - head);
   assign full        = (ptr_diff == fl_ptr_t'(FL_DEPTH));
   assign free_count  = (PR_BITS+1)'(ptr_diff);
   assign alloc_valid = (ptr_diff != '0) && !flush;
   assign alloc_phys  = entries[head[FL_IDX_BITS-1:0]];

   assign do_alloc        = alloc_req && alloc_valid;
   assign do_push         = commit_en && (commit_old_phys != '0) && !full;
   assign commit_head_nxt = fl_ptr_t'(commit_head + fl_ptr_t'(commit_en));

   // Flush rewinds head to the committed point, including this cycle's retirement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < FL_DEPTH; i++) begin
            entries[i] <= PR_BITS'(ARCH_REGS + i);
         end
         head        <= '0;
         tail        <= fl_ptr_t'(FL_DEPTH);
         commit_head <= '0;
      end else begin
         if (do_push) begin
            entries[tail[FL_IDX_BITS-1:0]] <= commit_old_phys;
            tail                           <= fl_ptr_t'(tail + 1'b1);
         end
         commit_head <= commit_head_nxt;
         if (flush) begin
            head <= commit_head_nxt;
         end else if (do_alloc) begin
            head <= fl_ptr_t'(head + 1'b1);
         end
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(commit_en && (commit_old_phys != '0) && full))
      else $error("free_list: tag returned while list is full");

   a_commit_behind_head : assert property (@(posedge clk) disable iff (rst)
      fl_ptr_t'(head - commit_head) <= fl_ptr_t'(FL_DEPTH))
      else $error("free_list: commit_head passed head");

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list against a queue-based model of free and in-flight tags.
module tb_free_list;
   import rename_pkg::*;

   logic               clk;
   logic               rst;
   logic               alloc_req;
   logic               alloc_valid;
   logic [PR_BITS-1:0] alloc_phys;
   logic               commit_en;
   logic [PR_BITS-1:0] commit_old_phys;
   logic               flush;
   logic [PR_BITS:0]   free_count;

   free_list dut (
      .clk             (clk),
      .rst             (rst),
      .alloc_req       (alloc_req),
      .alloc_valid     (alloc_valid),
      .alloc_phys      (alloc_phys),
      .commit_en       (commit_en),
      .commit_old_phys (commit_old_phys),
      .flush           (flush),
      .free_count      (free_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       valid;
      logic       chk_phys;
      logic [5:0] phys;
      int         cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Model: free tags in allocation order, and allocated-but-uncommitted tags oldest first.
   int free_q[$];
   int spec_q[$];

   function automatic void model_reset();
      free_q = {};
      spec_q = {};
      for (int i = 0; i < 32; i++) free_q.push_back(32 + i);
   endfunction

   // Monitor: compares DUT outputs mid-cycle against the oldest pending expectation.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_tests++;
         if (alloc_valid !== e.valid) begin
            n_fail++;
            $display("FAIL %s alloc_valid: got %0b expected %0b", e.name, alloc_valid, e.valid);
         end
         n_tests++;
         if (free_count !== 7'(e.cnt)) begin
            n_fail++;
            $display("FAIL %s free_count: got %0d expected %0d", e.name, free_count, e.cnt);
         end
         if (e.chk_phys) begin
            n_tests++;
            if (alloc_phys !== e.phys) begin
               n_fail++;
               $display("FAIL %s alloc_phys: got %0d expected %0d", e.name, alloc_phys, e.phys);
            end
         end
      end
   end

   function automatic void push_exp(input string name, input logic fl);
      exp_t e;
      e.name     = name;
      e.valid    = (free_q.size() != 0) && !fl;
      e.chk_phys = e.valid;
      e.phys     = e.valid ? 6'(free_q[0]) : 6'd0;
      e.cnt      = free_q.size();
      exp_q.push_back(e);
   endfunction

   task automatic do_reset(input string name);
      rst = 1'b1;
      alloc_req = 1'b0; commit_en = 1'b0; commit_old_phys = '0; flush = 1'b0;
      model_reset();
      push_exp(name, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic step(input string name, input logic a, input logic c,
                       input logic [5:0] o, input logic f);
      alloc_req = a; commit_en = c; commit_old_phys = o; flush = f;
      push_exp(name, f);
      if (a && !f && free_q.size() != 0) spec_q.push_back(free_q.pop_front());
      if (c) begin
         if (spec_q.size() != 0) void'(spec_q.pop_front());
         if (o != 0) free_q.push_back(int'(o));
      end
      if (f) begin
         free_q = {spec_q, free_q};
         spec_q = {};
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      alloc_req = 1'b0; commit_en = 1'b0; commit_old_phys = '0; flush = 1'b0;
      @(posedge clk); #1;
      do_reset("reset");

      // Drain the list completely, then one stalled request.
      for (int i = 0; i < 32; i++) step("drain", 1'b1, 1'b0, 6'd0, 1'b0);
      step("empty_stall", 1'b1, 1'b0, 6'd0, 1'b0);
      step("empty_hold", 1'b0, 1'b0, 6'd0, 1'b0);

      // Return into an empty list: not allocatable until the next cycle.
      step("no_bypass", 1'b1, 1'b1, 6'd7, 1'b0);
      step("after_bypass", 1'b0, 1'b0, 6'd0, 1'b0);

      // Flush recovery after 5 allocations and 2 commits.
      do_reset("reset2");
      for (int i = 0; i < 5; i++) step("alloc5", 1'b1, 1'b0, 6'd0, 1'b0);
      step("commit3", 1'b0, 1'b1, 6'd3, 1'b0);
      step("commit4", 1'b0, 1'b1, 6'd4, 1'b0);
      step("flush", 1'b1, 1'b0, 6'd0, 1'b1);
      for (int i = 0; i < 32; i++) step("post_flush", 1'b1, 1'b0, 6'd0, 1'b0);
      step("post_flush_empty", 1'b1, 1'b0, 6'd0, 1'b0);

      // Simultaneous alloc and commit at free_count 20, then a zero-tag commit.
      do_reset("reset3");
      for (int i = 0; i < 12; i++) step("to20", 1'b1, 1'b0, 6'd0, 1'b0);
      for (int i = 0; i < 10; i++) step("alloc_commit", 1'b1, 1'b1, 6'd9, 1'b0);
      step("commit_zero", 1'b0, 1'b1, 6'd0, 1'b0);
      step("zero_hold", 1'b0, 1'b0, 6'd0, 1'b0);
      step("flush_commit", 1'b0, 1'b1, 6'd11, 1'b1);
      for (int i = 0; i < 34; i++) step("drain2", 1'b1, 1'b0, 6'd0, 1'b0);

      // Reset in the middle of traffic with 3 tags free.
      do_reset("reset4");
      for (int i = 0; i < 29; i++) step("to3", 1'b1, 1'b0, 6'd0, 1'b0);
      step("at3", 1'b0, 1'b1, 6'd5, 1'b0);
      do_reset("mid_reset");

      // Randomized traffic; commits only retire in-flight allocations.
      for (int i = 0; i < 3000; i++) begin
         logic       a, c, f;
         logic [5:0] o;
         a = ($urandom % 4) != 0;
         c = (spec_q.size() != 0) && (($urandom % 2) == 0);
         o = (($urandom % 8) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
         f = ($urandom % 40) == 0;
         step("random", a, c, o, f);
      end

      alloc_req = 1'b0; commit_en = 1'b0; flush = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_queue: %0d expectations pending, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
